// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, LSB first.
// Drains a show-ahead FIFO (data/empty/rdreq) and drives the TX pad.
// Bit time is CLKS_PER_BIT system clocks; IDLE lasts one cycle between
// back-to-back frames, so the frame period is 10*CLKS_PER_BIT+1 cycles.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_empty,
  output logic       o_read,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Frame sequencer; every output is a register so the pad never glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      o_read   <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
          o_read <= 1'b0;
          // The head word is only trusted here; pop-induced changes
          // during the frame are never looked at.
          if (!i_empty) begin
            shift    <= i_data;
            o_read   <= 1'b1;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            baud_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          o_read <= 1'b0;
          if (baud_done) begin
            baud_cnt <= '0;
            o_tx     <= shift[0];
            bit_idx  <= 3'd0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx != 3'd7) begin
              shift   <= {1'b0, shift[7:1]};
              o_tx    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end else begin
              o_tx  <= 1'b1;
              state <= S_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            o_busy   <= 1'b0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO models feed two instances (fast bit time and
// 115200-baud timing); expected bytes go into queues at push time and
// independent line monitors pop and compare as frames appear.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int C2 = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_empty = 1'b1;
  logic       o_read, o_tx, o_busy;
  logic [7:0] i_data2 = 8'h00;
  logic       i_empty2 = 1'b1;
  logic       o_read2, o_tx2, o_busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_empty(i_empty),
    .o_read(o_read), .o_tx(o_tx), .o_busy(o_busy)
  );

  uart_tx #(.CLKS_PER_BIT(C2)) dut_lb (
    .i_clk(clk), .i_rst(rst), .i_data(i_data2), .i_empty(i_empty2),
    .o_read(o_read2), .o_tx(o_tx2), .o_busy(o_busy2)
  );

  initial forever #5 clk = ~clk;

  // Cycle counter, used to time frame starts.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- FIFO model, fast instance ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       ovr_en = 1'b0;
  logic       ovr_empty = 1'b1;
  logic [7:0] ovr_data = 8'h00;
  int         n_reads = 0;

  // Show-ahead FIFO: pops on a sampled read pulse, updates head mid-cycle.
  always @(negedge clk) begin
    if (o_read === 1'b1) begin
      n_reads++;
      check("read_nonempty", 32'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (ovr_en) begin
      i_empty = ovr_empty;
      i_data  = ovr_data;
    end else begin
      i_empty = (fifo_q.size() == 0);
      i_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // ---------------- line monitor, fast instance ----------------
  logic       m_act = 1'b0;
  int         m_cyc = 0;
  int         m_bit = 0;
  logic [9:0] m_bits;
  logic       m_ok;
  int         starts[$];
  int         n_frames = 0;

  // Captures each frame cycle by cycle: every level must hold C cycles.
  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (o_tx === 1'b0) begin
        m_act = 1'b1;
        m_cyc = 1;
        m_bits = '1;
        m_bits[0] = 1'b0;
        m_ok = 1'b1;
        starts.push_back(cyc);
        check("start_read", 32'(o_read), 1);
        check("start_busy", 32'(o_busy), 1);
      end else begin
        check("idle_busy", 32'(o_busy), 0);
        check("idle_read", 32'(o_read), 0);
      end
    end else begin
      m_bit = m_cyc / C;
      if (m_cyc % C == 0) m_bits[m_bit] = o_tx;
      else if (o_tx !== m_bits[m_bit]) m_ok = 1'b0;
      if (o_busy !== 1'b1 || o_read !== 1'b0) m_ok = 1'b0;
      m_cyc++;
      if (m_cyc == 10 * C) begin
        m_act = 1'b0;
        n_frames++;
        check("frame_shape", 32'({m_ok, m_bits[0], m_bits[9]}), 32'b101);
        check("frame_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("frame_data", 32'(m_bits[8:1]), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- FIFO model + receiver, 115200-baud instance ----------------
  logic [7:0] fifo2_q[$];
  logic [7:0] exp2_q[$];
  int         n_reads2 = 0;
  int         n_lb = 0;

  always @(negedge clk) begin
    if (o_read2 === 1'b1) begin
      n_reads2++;
      if (fifo2_q.size() != 0) void'(fifo2_q.pop_front());
    end
    i_empty2 = (fifo2_q.size() == 0);
    i_data2  = (fifo2_q.size() != 0) ? fifo2_q[0] : 8'h00;
  end

  // Conventional mid-bit sampling receiver.
  initial begin
    logic       b_start, b_stop;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (!rst && o_tx2 === 1'b0) begin
        repeat (C2 / 2) @(negedge clk);
        b_start = o_tx2;
        for (int k = 0; k < 8; k++) begin
          repeat (C2) @(negedge clk);
          rx[k] = o_tx2;
        end
        repeat (C2) @(negedge clk);
        b_stop = o_tx2;
        check("lb_framing", 32'({b_start, b_stop}), 32'b01);
        check("lb_pending", 32'(exp2_q.size() > 0), 1);
        if (exp2_q.size() > 0) check("lb_data", 32'(rx), 32'(exp2_q.pop_front()));
        n_lb++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int p_cyc;

  task automatic push(input logic [7:0] d);
    @(posedge clk);
    #1;
    fifo_q.push_back(d);
    exp_q.push_back(d);
    p_cyc = cyc;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && n_frames < target; i++) @(negedge clk);
    check("frame_timeout", 32'(n_frames >= target), 1);
  endtask

  task automatic wait_start(input int s0);
    for (int i = 0; i < 20 && starts.size() == s0; i++) @(negedge clk);
    check("start_seen", 32'(starts.size()), 32'(s0 + 1));
  endtask

  initial begin
    int r0, f0, s0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(o_tx),   1);
    check("rst_read", 32'(o_read), 0);
    check("rst_busy", 32'(o_busy), 0);
    #1 rst = 1'b0;

    // Single byte, start latency one edge after the FIFO goes non-empty.
    r0 = n_reads; f0 = n_frames;
    push(8'hA5);
    wait_frames(f0 + 1, 60);
    check("t1_latency", 32'(starts[starts.size()-1] - p_cyc), 1);
    check("t1_reads", 32'(n_reads - r0), 1);

    // Back-to-back frames, one idle cycle between.
    r0 = n_reads; f0 = n_frames; s0 = starts.size();
    push(8'h00);
    push(8'hFF);
    wait_frames(f0 + 2, 120);
    check("t2_starts", 32'(starts.size() - s0), 2);
    if (starts.size() >= s0 + 2) check("t2_gap", 32'(starts[s0+1] - starts[s0]), 41);
    check("t2_reads", 32'(n_reads - r0), 2);
    check("t2_empty", 32'(i_empty), 1);

    // Long empty stretch.
    r0 = n_reads;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("t3_idle", 32'({o_tx, o_read, o_busy}), 32'b100);
    end
    check("t3_reads", 32'(n_reads - r0), 0);

    // Reset during data bit 3 of 0x3C, then 0x81 queued at release.
    s0 = starts.size();
    push(8'h3C);
    wait_start(s0);
    while (cyc - starts[starts.size()-1] < 17) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_tx",   32'(o_tx),   1);
    check("t4_rst_busy", 32'(o_busy), 0);
    check("t4_popped",   32'(fifo_q.size()), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    f0 = n_frames;
    push(8'h81);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t4_restart", 32'({o_tx, o_read, o_busy}), 32'b011);
    wait_frames(f0 + 1, 60);

    // Head word and empty flag churn mid-frame must not leak into the frame.
    r0 = n_reads; f0 = n_frames; s0 = starts.size();
    push(8'h5A);
    wait_start(s0);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      ovr_en = 1'b1;
      ovr_empty = i[0];
      ovr_data = 8'(8'h11 * i + 8'h3);
    end
    @(posedge clk);
    #1 ovr_en = 1'b0;
    wait_frames(f0 + 1, 60);
    check("t5_reads", 32'(n_reads - r0), 1);

    // 115200-baud instance: three bytes through the receiver.
    r0 = n_reads2;
    fifo2_q.push_back(8'h48); exp2_q.push_back(8'h48);
    fifo2_q.push_back(8'h69); exp2_q.push_back(8'h69);
    fifo2_q.push_back(8'h0A); exp2_q.push_back(8'h0A);
    for (int i = 0; i < 3 * 10 * C2 + 2000 && n_lb < 3; i++) @(negedge clk);
    check("lb_count", 32'(n_lb), 3);
    check("lb_reads", 32'(n_reads2 - r0), 3);
    check("lb_empty", 32'(i_empty2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
